// File: rtl/gpio_pixel_pkg.sv
// gpio_pixel_pkg: shared constants, capture FSM state type and the lane saturation helper
// used by the GPIO-to-pixel packer.
//   LANES/LANE_W : four 32-bit unsigned lanes on the GPIO result bus
//   CH_W/PIX_W   : 8-bit colour channels packed into a 24-bit {R,G,B} pixel

package gpio_pixel_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned PIX_W  = 24;

    typedef enum logic [1:0] {
        WAIT_R,
        WAIT_G,
        WAIT_B
    } cap_state_t;

    // One 8-bit channel value per lane.
    typedef logic [LANES-1:0][CH_W-1:0] lane_bank_t;

    // Saturate an unsigned 32-bit lane to 8 bits.
    function automatic logic [CH_W-1:0] sat8(input logic [LANE_W-1:0] v);
        return (v > LANE_W'(255)) ? '1 : v[CH_W-1:0];
    endfunction

endpackage

// File: rtl/gpio_lane_clamp.sv
// gpio_lane_clamp: combinational saturation of the four 32-bit GPIO lanes to 8 bits each.
//   lanes_i   : 128-bit bus, lane n in bits [32n+31:32n]
//   clamped_o : per-lane 8-bit saturated value, index n = lane n

module gpio_lane_clamp
    import gpio_pixel_pkg::*;
(
    input  logic [LANES*LANE_W-1:0] lanes_i,
    output lane_bank_t              clamped_o
);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        assign clamped_o[n] = sat8(lanes_i[n*LANE_W +: LANE_W]);
    end

endmodule

// File: rtl/gpio_pixel_packer.sv
// gpio_pixel_packer: collects clamped R, G and B lane words from the processor GPIO bus into
// a group of four pixels and streams them out one per handshake with a frame-relative address.
//   clk, rst                  : clock, asynchronous active-high reset
//   GPIO                      : four 32-bit result lanes, lane 0 = first pixel
//   GPIOEn                    : start marker, arms the block
//   GPIOEnR/GPIOEnG/GPIOEnB   : GPIO carries the red/green/blue words of the current group
//   pix_data/pix_addr         : {R,G,B} pixel and its frame index
//   pix_valid/pix_ready       : output stream handshake
//   frame_done                : one-cycle pulse after pixel PIXELS-1 is accepted
//   armed                     : GPIOEn seen since reset
//   err_order, err_overflow   : sticky strobe-sequence and dropped-strobe flags

module gpio_pixel_packer
    import gpio_pixel_pkg::*;
#(
    parameter int unsigned PIXELS = 65536,
    parameter int unsigned ADDR_W = $clog2(PIXELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] GPIO,
    input  logic                    GPIOEn,
    input  logic                    GPIOEnR,
    input  logic                    GPIOEnG,
    input  logic                    GPIOEnB,
    output logic [PIX_W-1:0]        pix_data,
    output logic [ADDR_W-1:0]       pix_addr,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    frame_done,
    output logic                    armed,
    output logic                    err_order,
    output logic                    err_overflow
);

    localparam int unsigned       IDX_W     = $clog2(LANES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 1);

    lane_bank_t clamped;

    gpio_lane_clamp u_clamp (
        .lanes_i   (GPIO),
        .clamped_o (clamped)
    );

    cap_state_t        state_q;
    lane_bank_t        cap_r_q, cap_g_q, cap_b_q;
    lane_bank_t        out_r_q, out_g_q, out_b_q;
    logic              cap_full_q;
    logic              out_full_q;
    logic [IDX_W-1:0]  lane_idx_q;
    logic [ADDR_W-1:0] pix_addr_q;
    logic              frame_done_q;
    logic              armed_q;
    logic              err_order_q;
    logic              err_overflow_q;

    logic rgb_hit;
    logic handshake;

    // GPIOEn outranks colour strobes; colour strobes only count once armed.
    assign rgb_hit   = !GPIOEn && armed_q && (GPIOEnR || GPIOEnG || GPIOEnB);
    assign handshake = out_full_q && pix_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= WAIT_R;
            cap_r_q        <= '0;
            cap_g_q        <= '0;
            cap_b_q        <= '0;
            out_r_q        <= '0;
            out_g_q        <= '0;
            out_b_q        <= '0;
            cap_full_q     <= 1'b0;
            out_full_q     <= 1'b0;
            lane_idx_q     <= '0;
            pix_addr_q     <= '0;
            frame_done_q   <= 1'b0;
            armed_q        <= 1'b0;
            err_order_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // Capture side
            if (GPIOEn) begin
                armed_q <= 1'b1;
            end else if (rgb_hit) begin
                if (cap_full_q) begin
                    // Capture bank still waiting for the output bank: drop, keep FSM.
                    err_overflow_q <= 1'b1;
                end else if (GPIOEnR) begin
                    cap_r_q <= clamped;
                    state_q <= WAIT_G;
                    if (state_q != WAIT_R) err_order_q <= 1'b1;
                end else if (GPIOEnG) begin
                    if (state_q == WAIT_G) begin
                        cap_g_q <= clamped;
                        state_q <= WAIT_B;
                    end else begin
                        err_order_q <= 1'b1;
                        state_q     <= WAIT_R;
                    end
                end else begin
                    if (state_q == WAIT_B) begin
                        cap_b_q    <= clamped;
                        cap_full_q <= 1'b1;
                    end else begin
                        err_order_q <= 1'b1;
                    end
                    state_q <= WAIT_R;
                end
            end

            // Output side; handshake and transfer are exclusive on out_full_q.
            if (handshake) begin
                lane_idx_q   <= lane_idx_q + 1'b1;
                pix_addr_q   <= (pix_addr_q == ADDR_LAST) ? '0 : pix_addr_q + 1'b1;
                frame_done_q <= (pix_addr_q == ADDR_LAST);
                if (lane_idx_q == IDX_LAST) out_full_q <= 1'b0;
            end

            if (cap_full_q && !out_full_q) begin
                out_r_q    <= cap_r_q;
                out_g_q    <= cap_g_q;
                out_b_q    <= cap_b_q;
                cap_full_q <= 1'b0;
                out_full_q <= 1'b1;
                lane_idx_q <= '0;
            end
        end
    end

    assign pix_data     = {out_r_q[lane_idx_q], out_g_q[lane_idx_q], out_b_q[lane_idx_q]};
    assign pix_addr     = pix_addr_q;
    assign pix_valid    = out_full_q;
    assign frame_done   = frame_done_q;
    assign armed        = armed_q;
    assign err_order    = err_order_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_gpio_pixel_packer.sv
// tb_gpio_pixel_packer: directed and randomized stimulus for gpio_pixel_packer (PIXELS = 8),
// checked against a behavioural model of the strobe rules and an in-order pixel scoreboard.

module tb_gpio_pixel_packer;

    localparam int unsigned PIX = 8;

    logic         clk;
    logic         rst;
    logic [127:0] GPIO;
    logic         GPIOEn, GPIOEnR, GPIOEnG, GPIOEnB;
    logic [23:0]  pix_data;
    logic [2:0]   pix_addr;
    logic         pix_valid;
    logic         pix_ready;
    logic         frame_done;
    logic         armed;
    logic         err_order;
    logic         err_overflow;

    gpio_pixel_packer #(.PIXELS(PIX)) dut (
        .clk          (clk),
        .rst          (rst),
        .GPIO         (GPIO),
        .GPIOEn       (GPIOEn),
        .GPIOEnR      (GPIOEnR),
        .GPIOEnG      (GPIOEnG),
        .GPIOEnB      (GPIOEnB),
        .pix_data     (pix_data),
        .pix_addr     (pix_addr),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .frame_done   (frame_done),
        .armed        (armed),
        .err_order    (err_order),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ready: either directed or random per cycle
    logic ready_ctl = 1'b0;
    logic rnd_ready = 1'b0;
    logic rnd_bit   = 1'b0;
    assign pix_ready = rnd_ready ? rnd_bit : ready_ctl;
    always @(negedge clk) rnd_bit <= ($urandom_range(0, 2) != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model of the strobe rules ----------------
    bit         m_armed, m_ord, m_ovf;
    int         m_next;      // 0: expect R, 1: expect G, 2: expect B
    int         n_done;      // groups completed since reset
    logic [7:0] m_r[4];
    logic [7:0] m_g[4];
    logic [23:0] exp_q[$];

    function automatic logic [7:0] sat_ref(input logic [31:0] v);
        if (v > 32'd255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [127:0] rand_lanes();
        logic [127:0] v;
        for (int i = 0; i < 4; i++)
            v[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
        return v;
    endfunction

    task automatic model(input bit en, input bit r, input bit g, input bit b,
                         input logic [127:0] d, input bit drop);
        if (en) begin
            m_armed = 1;
        end else if (m_armed && (r || g || b)) begin
            if (drop) begin
                m_ovf = 1;
            end else if (r) begin
                for (int i = 0; i < 4; i++) m_r[i] = sat_ref(d[32*i +: 32]);
                if (m_next != 0) m_ord = 1;
                m_next = 1;
            end else if (g) begin
                if (m_next == 1) begin
                    for (int i = 0; i < 4; i++) m_g[i] = sat_ref(d[32*i +: 32]);
                    m_next = 2;
                end else begin
                    m_ord  = 1;
                    m_next = 0;
                end
            end else begin
                if (m_next == 2) begin
                    for (int i = 0; i < 4; i++)
                        exp_q.push_back({m_r[i], m_g[i], sat_ref(d[32*i +: 32])});
                    n_done++;
                end else begin
                    m_ord = 1;
                end
                m_next = 0;
            end
        end
    endtask

    // ---------------- output monitor / scoreboard ----------------
    int         acc_cnt  = 0;
    int         fd_count = 0;
    logic [2:0] exp_addr = '0;
    logic       fd_exp   = 1'b0;
    logic       stall_prev = 1'b0;
    logic [23:0] prev_data;
    logic [2:0]  prev_addr;

    always @(posedge clk) begin
        logic [23:0] p;
        if (rst) begin
            exp_q.delete();
            exp_addr   <= '0;
            acc_cnt    <= 0;
            fd_count   <= 0;
            fd_exp     <= 1'b0;
            stall_prev <= 1'b0;
        end else begin
            check("frame_done", frame_done, fd_exp);
            if (frame_done) fd_count <= fd_count + 1;
            if (stall_prev) begin
                check("stall_data", pix_data, prev_data);
                check("stall_addr", pix_addr, prev_addr);
            end
            fd_exp <= 1'b0;
            if (pix_valid && pix_ready) begin
                check("pixel_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    check("pix_data", pix_data, p);
                end
                check("pix_addr", pix_addr, exp_addr);
                fd_exp   <= (exp_addr == 3'(PIX - 1));
                exp_addr <= exp_addr + 3'd1;
                acc_cnt  <= acc_cnt + 1;
            end
            stall_prev <= pix_valid && !pix_ready;
            prev_data  <= pix_data;
            prev_addr  <= pix_addr;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Hold off strobes while the capture bank may still be full.
    task automatic pace();
        int budget = 400;
        while (acc_cnt < 4 * (n_done - 1) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("pace_timeout", acc_cnt >= 4 * (n_done - 1), 1);
        @(negedge clk);
    endtask

    task automatic strobe(input bit en, input bit r, input bit g, input bit b,
                          input logic [127:0] d, input bit drop);
        if ((r || g || b) && !drop) pace();
        GPIO = d; GPIOEn = en; GPIOEnR = r; GPIOEnG = g; GPIOEnB = b;
        @(negedge clk);
        GPIOEn = 0; GPIOEnR = 0; GPIOEnG = 0; GPIOEnB = 0;
        GPIO = {$urandom, $urandom, $urandom, $urandom};
        model(en, r, g, b, d, drop);
    endtask

    task automatic group(input logic [127:0] r, input logic [127:0] g, input logic [127:0] b);
        strobe(0, 1, 0, 0, r, 0);
        strobe(0, 0, 1, 0, g, 0);
        strobe(0, 0, 0, 1, b, 0);
    endtask

    task automatic wait_acc(input int n);
        int budget = 500;
        while (acc_cnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_timeout", acc_cnt >= n, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        m_armed = 0; m_ord = 0; m_ovf = 0; m_next = 0; n_done = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_armed"}, armed, m_armed);
        check({tag, "_err_order"}, err_order, m_ord);
        check({tag, "_err_overflow"}, err_overflow, m_ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        rst = 1; GPIO = '0; GPIOEn = 0; GPIOEnR = 0; GPIOEnG = 0; GPIOEnB = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_addr", pix_addr, 0);
        check("rst_fd", frame_done, 0);
        check_flags("rst");
        rst = 0;
        @(negedge clk);

        // Arming: colour strobes ignored before GPIOEn
        ready_ctl = 1;
        group(rand_lanes(), rand_lanes(), rand_lanes());
        repeat (4) @(negedge clk);
        check("unarmed_valid", pix_valid, 0);
        check_flags("unarmed");
        strobe(1, 1, 0, 0, rand_lanes(), 0);   // GPIOEn outranks R
        check_flags("arm");

        // Clamp, lane order and latency
        group({32'h7, 32'h0, 32'hFF, 32'h12C}, {4{32'h40}}, {32'h3, 32'h2, 32'h1, 32'h80000000});
        check("lat_valid_k", pix_valid, 0);
        @(negedge clk);
        check("lat_valid_k1", pix_valid, 1);
        check("first_data", pix_data, 24'hFF40FF);
        check("first_addr", pix_addr, 0);
        wait_acc(4);
        check("gap_after_group", pix_valid, 0);

        // Backpressure mid-group
        base = acc_cnt;
        group(rand_lanes(), rand_lanes(), rand_lanes());
        wait_acc(base + 2);
        ready_ctl = 0;
        repeat (5) @(negedge clk);
        check("bp_held", acc_cnt, base + 2);
        check("bp_valid", pix_valid, 1);
        ready_ctl = 1;
        wait_acc(base + 4);

        // Order error: G while waiting for R, then a clean group
        strobe(0, 0, 1, 0, rand_lanes(), 0);
        check_flags("order");
        check("order_no_out", pix_valid, 0);
        base = acc_cnt;
        group(rand_lanes(), rand_lanes(), rand_lanes());
        wait_acc(base + 4);

        // Overflow with both banks full
        do_reset();
        strobe(1, 0, 0, 0, '0, 0);
        ready_ctl = 0;
        group(rand_lanes(), rand_lanes(), rand_lanes());
        group(rand_lanes(), rand_lanes(), rand_lanes());
        repeat (3) @(negedge clk);
        strobe(0, 1, 0, 0, rand_lanes(), 1);
        strobe(0, 0, 1, 0, rand_lanes(), 1);
        check_flags("ovf");
        ready_ctl = 1;
        wait_acc(8);
        repeat (4) @(negedge clk);
        check("ovf_count", acc_cnt, 8);
        check("ovf_left", exp_q.size(), 0);
        base = acc_cnt;
        group(rand_lanes(), rand_lanes(), rand_lanes());
        wait_acc(base + 4);
        check_flags("ovf_after");

        // Address wrap and frame_done
        do_reset();
        strobe(1, 0, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++) group(rand_lanes(), rand_lanes(), rand_lanes());
        wait_acc(12);
        @(negedge clk);
        check("wrap_fd_count", fd_count, 12 / PIX);
        check("wrap_addr", pix_addr, 12 % PIX);

        // Reset mid-group
        ready_ctl = 0;
        group(rand_lanes(), rand_lanes(), rand_lanes());
        strobe(0, 1, 0, 0, rand_lanes(), 0);
        strobe(0, 0, 1, 0, rand_lanes(), 0);
        strobe(0, 0, 1, 0, rand_lanes(), 0);   // order error so err_order is set before reset
        repeat (2) @(negedge clk);
        check("pre_rst_valid", pix_valid, 1);
        check("pre_rst_err", err_order, 1);
        rst = 1;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_addr", pix_addr, 0);
        check("mid_rst_armed", armed, 0);
        check("mid_rst_err", err_order, 0);
        do_reset();
        ready_ctl = 1;
        repeat (6) @(negedge clk);
        check("post_rst_valid", pix_valid, 0);
        check("post_rst_acc", acc_cnt, 0);

        // Randomized strobes with random backpressure
        strobe(1, 0, 0, 0, '0, 0);
        rnd_ready = 1;
        for (int it = 0; it < 150; it++) begin
            bit en, r, g, b;
            if ($urandom_range(0, 4) != 0) begin
                en = 0; r = (m_next == 0); g = (m_next == 1); b = (m_next == 2);
            end else begin
                en = ($urandom_range(0, 3) == 0);
                r  = 1'($urandom_range(0, 1));
                g  = 1'($urandom_range(0, 1));
                b  = 1'($urandom_range(0, 1));
            end
            strobe(en, r, g, b, rand_lanes(), 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rnd_ready = 0;
        ready_ctl = 1;
        wait_acc(4 * n_done);
        repeat (4) @(negedge clk);
        check("rnd_count", acc_cnt, 4 * n_done);
        check("rnd_left", exp_q.size(), 0);
        check_flags("rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
